des_subkey_gen: RTL and testbench

Sequential DES key-schedule generator for the Triple-DES datapath. It latches one 64-bit key and streams the sixteen 48-bit round subkeys one at a time over a valid/ready handshake. Subkeys come out in forward order K1..K16 for encryption or reverse order K16..K1 for decryption. It sits between the key register bank and the round engine that feeds the S-box stage, one instance per DES stage.

---
 rtl/des_pkg.sv | 54 +++++
 rtl/des_pc2.sv | 22 ++
 rtl/des_subkey_gen.sv | 141 ++++++++++++++
 tb/tb_des_subkey_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants and shared types.
// Holds the PC-1/PC-2 selection tables, the per-round shift schedule,
// the subkey type, the generator FSM state enum and small rotate/permute helpers.
package des_pkg;

   typedef logic [47:0] des_subkey_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } des_state_e;

   // Permuted choice 1: entry i is the DES key bit (1 = MSB) placed at C/D position i+1.
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   // Permuted choice 2: entry i is the C/D bit (1 = MSB of C) placed at subkey position i+1.
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Left-rotation amount before round k is SHIFT[k-1].
   localparam logic [1:0] SHIFT [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // DES bit 1 of a half is the MSB, so a DES left shift moves bits toward [27].
   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
      return (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
      return (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   // PC-1 of a 64-bit key; result is {C0, D0} with C0 in [55:28].
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         r[55-i] = k[64-PC1[i]];
      end
      return r;
   endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: combinational 56-bit {C,D} to 48-bit round subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [55:0]  cd_i,
   output des_subkey_t  subkey_o
);

   // Eight C/D positions (9,18,22,25,35,38,43,54) never reach a subkey.
   logic unused_cd_bits;
   assign unused_cd_bits = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                             cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

   // Fixed bit selection through the PC-2 table.
   always_comb begin
      subkey_o = '0;
      for (int i = 0; i < 48; i++) begin
         subkey_o[47-i] = cd_i[56-PC2[i]];
      end
   end

endmodule

// File: rtl/des_subkey_gen.sv
// Sequential DES key-schedule generator.
// Latches a 64-bit key on start and streams K1..K16 (encrypt) or K16..K1
// (decrypt) over a valid/ready handshake, one subkey per accepted transfer.
// Optional build macro DES_KEY_PARITY_EN: reject keys whose bytes lack odd
// parity with a one-cycle key_err pulse; otherwise key_err is always 0.
module des_subkey_gen
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   input  logic        start,
   input  logic        subkey_ready,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   output logic [3:0]  key_idx,
   output logic        busy,
   output logic        done,
   output logic        key_err
);

   des_state_e  state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [3:0]  pos_q, pos_d;
   logic        dir_q, dir_d;
   logic        done_q, done_d;
   logic        key_err_q, key_err_d;

   logic [55:0] cd_load;
   logic        key_ok;
   des_subkey_t pc2_out;

   assign cd_load = pc1(key_in);

`ifdef DES_KEY_PARITY_EN
   // Every key byte must carry odd parity for the load to be accepted.
   always_comb begin
      key_ok = 1'b1;
      for (int b = 0; b < 8; b++) begin
         if (^key_in[8*b +: 8] == 1'b0) key_ok = 1'b0;
      end
   end
`else
   // Parity bits are dropped by PC-1 and not checked in this build.
   logic unused_parity_bits;
   assign unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                 key_in[24], key_in[16], key_in[8],  key_in[0]};
   assign key_ok = 1'b1;
`endif

   des_pc2 u_pc2 (
      .cd_i     ({c_q, d_q}),
      .subkey_o (pc2_out)
   );

   // Next-state: key load in IDLE, rotate-and-advance on each accepted subkey.
   always_comb begin
      // NOTE: every signal gets its default first so no path leaves one unassigned and infers a latch.
      state_d   = state_q;
      c_d       = c_q;
      d_d       = d_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      done_d    = 1'b0;
      key_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (!key_ok) begin
                  key_err_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  dir_d   = decrypt;
                  pos_d   = 4'd0;
                  if (decrypt) begin
                     // C0/D0 equal C16/D16: the schedule rotates 28 places in total.
                     c_d = cd_load[55:28];
                     d_d = cd_load[27:0];
                  end else begin
                     c_d = rotl28(cd_load[55:28], SHIFT[0]);
                     d_d = rotl28(cd_load[27:0],  SHIFT[0]);
                  end
               end
            end
         end
         S_ISSUE: begin
            if (subkey_ready) begin
               if (pos_q == 4'd15) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  c_d     = '0;
                  d_d     = '0;
                  pos_d   = 4'd0;
               end else begin
                  pos_d = pos_q + 4'd1;
                  if (dir_q) begin
                     c_d = rotr28(c_q, SHIFT[4'd15 - pos_q]);
                     d_d = rotr28(d_q, SHIFT[4'd15 - pos_q]);
                  end else begin
                     c_d = rotl28(c_q, SHIFT[pos_q + 4'd1]);
                     d_d = rotl28(d_q, SHIFT[pos_q + 4'd1]);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any schedule in flight.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         c_q       <= '0;
         d_q       <= '0;
         pos_q     <= 4'd0;
         dir_q     <= 1'b0;
         done_q    <= 1'b0;
         key_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         c_q       <= c_d;
         d_q       <= d_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         done_q    <= done_d;
         key_err_q <= key_err_d;
      end
   end

   assign subkey_valid = (state_q == S_ISSUE);
   assign busy         = (state_q == S_ISSUE);
   assign subkey       = subkey_valid ? pc2_out : '0;
   assign key_idx      = dir_q ? (4'd15 - pos_q) : pos_q;
   assign done         = done_q;
   assign key_err      = key_err_q;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Self-checking bench for des_subkey_gen using the textbook DES key
// 133457799BBCDFF1 and its published round subkeys as the reference.
module tb_des_subkey_gen;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [63:0] key_in = '0;
   logic        decrypt = 1'b0;
   logic        start = 1'b0;
   logic        subkey_ready = 1'b0;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic [3:0]  key_idx;
   logic        busy;
   logic        done;
   logic        key_err;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [3:0]  idx;
      logic [47:0] key;
   } exp_t;

   exp_t sb_q[$];

   localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
   localparam logic [63:0] KEY_ALT = 64'h0123456789ABCDEF;

   // K1..K16 for KEY.
   logic [47:0] ref_k [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   des_subkey_gen dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .key_in       (key_in),
      .decrypt      (decrypt),
      .start        (start),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .key_idx      (key_idx),
      .busy         (busy),
      .done         (done),
      .key_err      (key_err)
   );

   always #5 clk = ~clk;

   // Queue the expected stream and raise start; the next posedge samples it.
   task automatic kick(input logic [63:0] k, input logic dec);
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         e.idx = dec ? 4'(15 - i) : 4'(i);
         e.key = ref_k[e.idx];
         sb_q.push_back(e);
      end
      key_in  = k;
      decrypt = dec;
      start   = 1'b1;
   endtask

   // Consume one schedule; returns at the negedge of the done cycle.
   task automatic drain(input bit rand_ready, input int inj_cyc, input logic [63:0] inj_key,
                        output int first_valid, output int done_cyc);
      int   n_xfer;
      bit   held;
      exp_t held_v;
      exp_t e;
      n_xfer = 0; held = 1'b0; held_v = '0; first_valid = 0; done_cyc = 0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(posedge clk); #1;
         start        = (cyc == inj_cyc);
         key_in       = (cyc == inj_cyc) ? inj_key : {$urandom, $urandom};
         decrypt      = 1'($urandom_range(0, 1));
         subkey_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (subkey_valid) begin
            if (first_valid == 0) first_valid = cyc;
            if (held) begin
               n_total++;
               if ({key_idx, subkey} !== held_v)
                  $display("FAIL hold_stable: got idx=%0d key=%h, want idx=%0d key=%h",
                           key_idx, subkey, held_v.idx, held_v.key);
               else n_pass++;
            end
            if (subkey_ready) begin
               held = 1'b0;
               n_total++;
               if (sb_q.size() == 0) begin
                  $display("FAIL extra_subkey: got idx=%0d key=%h, want none", key_idx, subkey);
               end else begin
                  e = sb_q.pop_front();
                  n_xfer++;
                  if ({key_idx, subkey} !== e)
                     $display("FAIL subkey: got idx=%0d key=%h, want idx=%0d key=%h",
                              key_idx, subkey, e.idx, e.key);
                  else n_pass++;
               end
            end else begin
               held   = 1'b1;
               held_v = {key_idx, subkey};
            end
         end
      end
      n_total++;
      if (done_cyc == 0) $display("FAIL done_timeout: got no done, want done within 400 cycles");
      else n_pass++;
      n_total++;
      if (n_xfer != 16 || sb_q.size() != 0)
         $display("FAIL stream_count: got %0d transfers with %0d left, want 16 with 0 left",
                  n_xfer, sb_q.size());
      else n_pass++;
      n_total++;
      if ({busy, subkey_valid, key_err} !== 3'b000)
         $display("FAIL done_flags: got busy/valid/err=%b, want 000", {busy, subkey_valid, key_err});
      else n_pass++;
      sb_q.delete();
   endtask

   task automatic check_timing(input string name, input int fv, input int dc);
      n_total++;
      if (fv !== 1) $display("FAIL %s_latency: got first valid at cycle %0d, want 1", name, fv);
      else n_pass++;
      n_total++;
      if (dc !== 17) $display("FAIL %s_done: got done at cycle %0d, want 17", name, dc);
      else n_pass++;
   endtask

   task automatic test_reset();
      #2;
      n_total++;
      if ({subkey, subkey_valid, key_idx, busy, done, key_err} !== '0)
         $display("FAIL reset_outputs: got key=%h v=%b idx=%0d busy=%b done=%b err=%b, want all 0",
                  subkey, subkey_valid, key_idx, busy, done, key_err);
      else n_pass++;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_encrypt();
      int fv, dc;
      kick(KEY, 1'b0);
      drain(1'b0, 0, '0, fv, dc);
      check_timing("enc", fv, dc);
      @(negedge clk);
   endtask

   task automatic test_decrypt();
      int fv, dc;
      kick(KEY, 1'b1);
      drain(1'b0, 0, '0, fv, dc);
      check_timing("dec", fv, dc);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int fv, dc;
      kick(KEY, 1'b0);
      drain(1'b1, 0, '0, fv, dc);
      @(negedge clk);
      kick(KEY, 1'b1);
      drain(1'b1, 0, '0, fv, dc);
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int fv, dc;
      kick(KEY, 1'b0);
      drain(1'b0, 5, KEY_ALT, fv, dc);
      check_timing("ign", fv, dc);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int fv, dc;
      kick(KEY, 1'b0);
      drain(1'b0, 0, '0, fv, dc);
      kick(KEY, 1'b1);
      drain(1'b0, 0, '0, fv, dc);
      check_timing("b2b", fv, dc);
      @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      int fv, dc;
      bit found;
      found = 1'b0;
      kick(KEY, 1'b0);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         subkey_ready = 1'b1;
         @(negedge clk);
         if (subkey_valid && key_idx == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      n_total++;
      if (!found) $display("FAIL rst_reach_pos7: got no key_idx 7, want it within 40 cycles");
      else n_pass++;
      sb_q.delete();
      n_rst = 1'b0;
      #1;
      n_total++;
      if ({subkey, subkey_valid, key_idx, busy, done, key_err} !== '0)
         $display("FAIL rst_async: got key=%h v=%b idx=%0d busy=%b done=%b err=%b, want all 0",
                  subkey, subkey_valid, key_idx, busy, done, key_err);
      else n_pass++;
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if ({done, busy} !== 2'b00)
            $display("FAIL rst_no_done: got done/busy=%b, want 00", {done, busy});
         else n_pass++;
      end
      kick(KEY, 1'b0);
      drain(1'b0, 0, '0, fv, dc);
      check_timing("rst", fv, dc);
      @(negedge clk);
   endtask

   task automatic test_parity();
`ifdef DES_KEY_PARITY_EN
      key_in  = KEY_BAD;
      decrypt = 1'b0;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_total++;
      if ({key_err, busy, subkey_valid} !== 3'b100)
         $display("FAIL parity_err: got err/busy/valid=%b, want 100", {key_err, busy, subkey_valid});
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_total++;
         if ({key_err, busy, subkey_valid} !== 3'b000)
            $display("FAIL parity_idle: got err/busy/valid=%b, want 000", {key_err, busy, subkey_valid});
         else n_pass++;
      end
`else
      int fv, dc;
      kick(KEY_BAD, 1'b0);
      drain(1'b0, 0, '0, fv, dc);
      check_timing("par", fv, dc);
      @(negedge clk);
`endif
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_start_ignored();
      test_back_to_back();
      test_reset_midstream();
      test_parity();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
